divisor_seq: RTL and testbench
==============================

// Module: divisor_seq
// PURPOSE
//  Sequential 32-bit integer divider for the EX stage; the inverse operation of the multiplier unit.
//  Performs MIPS DIV/DIVU via restoring shift-subtract on magnitudes, one quotient bit per clock.
//  Results are delivered in the same out_high/out_low convention as mult:
//    out_high = remainder (HI), out_low = quotient (LO).
//  The control unit pulses divOp, stalls on busy, and latches HI/LO on done.
// PARAMETERS
//  WIDTH  32  operand/result width; iteration count = WIDTH, counter width = $clog2(WIDTH)+1
// PORTS
//  clk         in   1      system clock, all state updates on posedge
//  reset_n     in   1      synchronous reset, active-low
//  divOp       in   1      start request, sampled on posedge only while idle
//  is_signed   in   1      1 = DIV (two's complement), 0 = DIVU; sampled with divOp
//  dividend    in   WIDTH  numerator, sampled with divOp
//  divisor     in   WIDTH  denominator, sampled with divOp
//  busy        out  1      high from the edge after divOp acceptance until the edge done rises
//  done        out  1      single-cycle pulse: out_high/out_low valid and updated
//  div_zero    out  1      set with done when divisor was 0; held until next accepted divOp
//  out_high    out  WIDTH  remainder; holds value until next completion
//  out_low     out  WIDTH  quotient; holds value until next completion
// BEHAVIOUR
//  Clock and reset: one clock, synchronous active-low reset.
//  reset_n=0 at a posedge:
//    - state<=IDLE; busy, done, div_zero <=0; out_high, out_low <=0.
//    - Aborts any operation in flight; no done is produced for it.
//  States:
//    IDLE, RUN, FIX, DONE_Z.
//  IDLE:
//    - divOp=1, divisor!=0: latch sign_q = is_signed&(dividend[31]^divisor[31]) and
//      sign_r = is_signed&dividend[31]; latch |dividend| and |divisor| (raw values if unsigned).
//    - Then clear remainder register R (WIDTH+1 bits), count<=0, busy<=1, div_zero<=0, ->RUN.
//    - divOp=1, divisor==0: busy<=1, div_zero<=1, ->DONE_Z.
//  RUN, each edge:
//    - {R,Q} <= {R,Q}<<1.
//    - If shifted R >= |divisor|: R <= R-|divisor| and Q[0] <= 1.
//    - count++; after WIDTH iterations ->FIX.
//  FIX:
//    - out_low <= sign_q ? -Q : Q.
//    - out_high <= sign_r ? -R[WIDTH-1:0] : R[WIDTH-1:0].
//    - done<=1, busy<=0, ->IDLE.
//  DONE_Z:
//    - out_high <= dividend, out_low <= {WIDTH{1'b1}}, done<=1, busy<=0, ->IDLE.
//  Latency: accepted on edge E; done high in the cycle after edge E+WIDTH+1 (33 edges at WIDTH=32);
//    divide-by-zero gives done after edge E+1.
//  done is high for exactly one cycle; it deasserts on the next edge regardless of divOp.
//  divOp while busy/RUN/FIX is ignored: no restart, no operand resample.
//  divOp high on the same edge done deasserts: accepted (state is IDLE).
//  Signed semantics: quotient truncates toward zero; remainder takes the dividend's sign
//    and satisfies dividend = q*divisor + r.
//  Overflow case 0x80000000 / -1 (signed): out_low=0x80000000, out_high=0. No flag.
//  Magnitude of 0x80000000 is 0x80000000 treated as unsigned; no internal overflow.
// TESTING
//  1. signed 100/7, divOp 1 cycle -> busy 33 cycles, done pulse; out_low=14, out_high=2, div_zero=0.
//  2. signed -100/7 -> out_low=0xFFFFFFF2, out_high=0xFFFFFFFE. signed 100/-7 -> out_low=0xFFFFFFF2, out_high=2.
//  3. unsigned 0xFFFFFFFF/2 -> out_low=0x7FFFFFFF, out_high=1. signed same operands -> out_low=0, out_high=0xFFFFFFFF.
//  4. divisor=0, dividend=0x1234 -> done 1 cycle after accept; div_zero=1, out_high=0x1234, out_low=0xFFFFFFFF.
//  5. signed 0x80000000/0xFFFFFFFF -> out_low=0x80000000, out_high=0. Second divOp mid-RUN -> ignored; result unchanged.
//  6. reset_n=0 at iteration 10 -> next cycle busy=0, outputs 0, no done. New 9/3 -> q=3, r=0 after 33 cycles.

Source files
------------

// File: rtl/divisor_seq.sv
// divisor_seq: sequential restoring divider for MIPS DIV/DIVU.
// Works on operand magnitudes, one quotient bit per clock, then fixes up signs.
// Results follow the multiplier convention: out_high = remainder, out_low = quotient.
module divisor_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             divOp,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] out_high,
  output logic [WIDTH-1:0] out_low
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE_Z
  } state_t;

  state_t state_q, state_d;

  // The remainder only ever holds values below |divisor|, so WIDTH bits suffice;
  // the extra bit of the working remainder lives in the shifted/diff values.
  logic [WIDTH-1:0] rem_q, rem_d;
  // Quotient register; also carries the raw dividend for the divide-by-zero path.
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    count_q, count_d;
  logic             signQ_q, signQ_d;
  logic             signR_q, signR_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             divZero_q, divZero_d;
  logic [WIDTH-1:0] outHigh_q, outHigh_d;
  logic [WIDTH-1:0] outLow_q, outLow_d;

  logic [WIDTH-1:0] absDividend;
  logic [WIDTH-1:0] absDivisor;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // Operand magnitudes; 0x80000000 maps onto itself, which is correct when read as unsigned.
  always_comb begin
    absDividend = (is_signed && dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
    absDivisor  = (is_signed && divisor[WIDTH-1])  ? (~divisor + 1'b1)  : divisor;
  end

  // One restoring step: shift the next dividend bit into R and trial-subtract the divisor.
  // The top bit of diff is the borrow, i.e. set exactly when shifted R < |divisor|.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: divOp is only looked at while idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (divOp) begin
          state_d = (divisor == '0) ? DONE_Z : RUN;
        end
      end
      RUN: begin
        if (count_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX:     state_d = IDLE;
      DONE_Z:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values for each state.
  always_comb begin
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    count_d   = count_q;
    signQ_d   = signQ_q;
    signR_d   = signR_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    divZero_d = divZero_q;
    outHigh_d = outHigh_q;
    outLow_d  = outLow_q;
    case (state_q)
      IDLE: begin
        if (divOp) begin
          busy_d = 1'b1;
          if (divisor == '0) begin
            divZero_d = 1'b1;
            quo_d     = dividend;
          end else begin
            divZero_d = 1'b0;
            signQ_d   = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            signR_d   = is_signed & dividend[WIDTH-1];
            quo_d     = absDividend;
            dvs_d     = absDivisor;
            rem_d     = '0;
            count_d   = '0;
          end
        end
      end
      RUN: begin
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        count_d = count_q + CW'(1);
      end
      FIX: begin
        outLow_d  = signQ_q ? (~quo_q + 1'b1) : quo_q;
        outHigh_d = signR_q ? (~rem_q + 1'b1) : rem_q;
        done_d    = 1'b1;
        busy_d    = 1'b0;
      end
      DONE_Z: begin
        outHigh_d = quo_q;
        outLow_d  = '1;
        done_d    = 1'b1;
        busy_d    = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers; reset abandons any division in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      count_q   <= '0;
      signQ_q   <= 1'b0;
      signR_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divZero_q <= 1'b0;
      outHigh_q <= '0;
      outLow_q  <= '0;
    end else begin
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      count_q   <= count_d;
      signQ_q   <= signQ_d;
      signR_q   <= signR_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      divZero_q <= divZero_d;
      outHigh_q <= outHigh_d;
      outLow_q  <= outLow_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = divZero_q;
  assign out_high = outHigh_q;
  assign out_low  = outLow_q;

endmodule

// File: tb/tb_divisor_seq.sv
// tb_divisor_seq: table of divide vectors plus hand-written corner sequences.
// Expected results go into a scoreboard queue when an operation is started and
// are popped and compared whenever the divider raises done.
module tb_divisor_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        divOp;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] out_high;
  logic [31:0] out_low;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } vec_t;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  exp_t monExp;

  divisor_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .divOp     (divOp),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .out_high  (out_high),
    .out_low   (out_low)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model built on the language's own division operators.
  function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output logic z);
    int sa;
    int sb2;
    z = 1'b0;
    if (b == 32'h0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'h0;
      end else begin
        sa  = a;
        sb2 = b;
        q   = sa / sb2;
        r   = sa % sb2;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Scoreboard: every done pops one expected result.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpectedDone: got done=1, expected no pending result");
      end else begin
        monExp = sb.pop_front();
        checkOutput("quotient", out_low, monExp.q);
        checkOutput("remainder", out_high, monExp.r);
        checkOutput("divZero", {31'b0, div_zero}, {31'b0, monExp.z});
      end
    end
  end

  // Drive one request for a single cycle; returns at the negedge after acceptance.
  task automatic startOp(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q, input logic [31:0] r, input logic z);
    exp_t e;
    e.q = q;
    e.r = r;
    e.z = z;
    is_signed = s;
    dividend  = a;
    divisor   = b;
    divOp     = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    divOp = 1'b0;
    checkOutput("busyAfterAccept", {31'b0, busy}, 32'h1);
  endtask

  // Wait (bounded) for done; startCycles counts negedges already seen since acceptance.
  task automatic waitDone(input int startCycles, input int expLat);
    int cycles;
    cycles = startCycles;
    while (done !== 1'b1 && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    if (done !== 1'b1) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL doneTimeout: got no done after %0d cycles, expected done at %0d", cycles, expLat);
    end else begin
      checkOutput("latency", cycles, expLat);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    startOp(v.sgn, v.a, v.b, v.q, v.r, v.z);
    waitDone(1, v.z ? 2 : 34);
  endtask

  initial begin
    vec_t v;
    int   extraDone;
    logic [31:0] rq, rr;
    logic        rz;

    vecs.push_back('{1'b1, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0});
    vecs.push_back('{1'b1, -32'sd100,      32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0});
    vecs.push_back('{1'b1, 32'd100,        -32'sd7,        32'hFFFF_FFF2,  32'd2,          1'b0});
    vecs.push_back('{1'b0, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  32'd1,          1'b0});
    vecs.push_back('{1'b1, 32'hFFFF_FFFF,  32'd2,          32'h0,          32'hFFFF_FFFF,  1'b0});
    vecs.push_back('{1'b0, 32'h1234,       32'h0,          32'hFFFF_FFFF,  32'h1234,       1'b1});
    vecs.push_back('{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'h0,          1'b0});
    vecs.push_back('{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          32'h8000_0000,  1'b0});
    vecs.push_back('{1'b1, -32'sd100,      -32'sd7,        32'd14,         32'hFFFF_FFFE,  1'b0});
    vecs.push_back('{1'b1, 32'hDEAD_BEEF,  32'h0,          32'hFFFF_FFFF,  32'hDEAD_BEEF,  1'b1});
    vecs.push_back('{1'b0, 32'd5,          32'd9,          32'd0,          32'd5,          1'b0});

    // Random vectors, expected values from the reference model.
    for (int i = 0; i < 6; i++) begin
      v.sgn = 1'($urandom_range(0, 1));
      v.a   = $urandom;
      v.b   = (i < 3) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (v.sgn && $urandom_range(0, 1) == 1) v.b = ~v.b + 32'd1;
      if (v.b == 32'h0) v.b = 32'd3;
      model(v.sgn, v.a, v.b, rq, rr, rz);
      v.q = rq;
      v.r = rr;
      v.z = rz;
      vecs.push_back(v);
    end

    // Reset state.
    reset_n   = 1'b0;
    divOp     = 1'b0;
    is_signed = 1'b0;
    dividend  = 32'h0;
    divisor   = 32'h0;
    repeat (3) @(negedge clk);
    checkOutput("resetBusy", {31'b0, busy}, 32'h0);
    checkOutput("resetDone", {31'b0, done}, 32'h0);
    checkOutput("resetDivZero", {31'b0, div_zero}, 32'h0);
    checkOutput("resetHigh", out_high, 32'h0);
    checkOutput("resetLow", out_low, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Table: even entries check the done pulse drop, odd ones chain back-to-back
    // so divOp is high on the very edge done falls.
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      if (i % 2 == 0) begin
        @(negedge clk);
        checkOutput("donePulse", {31'b0, done}, 32'h0);
        checkOutput("busyAfterDone", {31'b0, busy}, 32'h0);
      end
    end

    // div_zero and results hold until the next accepted operation.
    @(negedge clk);
    applyStimulus('{1'b0, 32'h1234, 32'h0, 32'hFFFF_FFFF, 32'h1234, 1'b1});
    repeat (5) @(negedge clk);
    checkOutput("divZeroHold", {31'b0, div_zero}, 32'h1);
    checkOutput("highHold", out_high, 32'h1234);
    startOp(1'b0, 32'd7, 32'd2, 32'd3, 32'd1, 1'b0);
    checkOutput("divZeroCleared", {31'b0, div_zero}, 32'h0);
    repeat (5) @(negedge clk);
    checkOutput("lowHoldMidRun", out_low, 32'hFFFF_FFFF);
    waitDone(6, 34);

    // Second request in the middle of RUN must be ignored.
    @(negedge clk);
    startOp(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0);
    repeat (9) @(negedge clk);
    is_signed = 1'b0;
    dividend  = 32'd5;
    divisor   = 32'd1;
    divOp     = 1'b1;
    @(negedge clk);
    divOp = 1'b0;
    checkOutput("busyIgnoredOp", {31'b0, busy}, 32'h1);
    waitDone(11, 34);
    extraDone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) extraDone++;
    end
    checkOutput("noRestart", extraDone, 32'h0);

    // Reset around iteration 10 aborts the division with no done.
    startOp(1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    sb.delete();
    @(negedge clk);
    checkOutput("abortBusy", {31'b0, busy}, 32'h0);
    checkOutput("abortDone", {31'b0, done}, 32'h0);
    checkOutput("abortHigh", out_high, 32'h0);
    checkOutput("abortLow", out_low, 32'h0);
    reset_n = 1'b1;
    extraDone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) extraDone++;
    end
    checkOutput("noDoneAfterAbort", extraDone, 32'h0);
    applyStimulus('{1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0});
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
